apb_master_arbiter: RTL and testbench

Round-robin arbiter that shares one APB master's command port among `NUM_REQ` requesters. It sits in front of the APB master. It latches the winning requester's command and drives the master's `transfer`/`write_read`/`addr_in`/`wdata_in`/`strb_in` inputs. It then holds the command until the master reports `transfer_done`, and routes `rdata_out`/`error` back to the owner. A watchdog completes hung transfers with a timeout error.

---
 rtl/apb_arb_pkg.sv | 35 +++
 rtl/apb_master_arbiter_if.sv | 28 ++
 rtl/apb_master_arbiter_rr_pick.sv | 31 +++
 rtl/apb_master_arbiter.sv | 149 ++++++++++++++
 tb/tb_apb_master_arbiter.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/apb_arb_pkg.sv
// Shared types for the APB command-port arbiter: FSM states and the latched command.
// Latency: n/a (types only).
// Backpressure: n/a.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

package apb_arb_pkg;

    localparam int APB_ADDR_W = `ADDR_WIDTH;
    localparam int APB_DATA_W = `DATA_WIDTH;
    localparam int APB_STRB_W = APB_DATA_W / 8;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

    // Command held toward the APB master for the whole transfer.
    typedef struct packed {
        logic                  write;
        logic [APB_ADDR_W-1:0] addr;
        logic [APB_DATA_W-1:0] wdata;
        logic [APB_STRB_W-1:0] strb;
    } apb_cmd_t;

    // The watchdog counter needs a 1-bit minimum so a disabled watchdog still elaborates.
    function automatic int cnt_width(input int t);
        return (t == 0) ? 1 : $clog2(t + 1);
    endfunction

endpackage

// File: rtl/apb_master_arbiter_if.sv
// Command/completion bundle between the arbiter and the APB master.
// Latency: wires only.
// Backpressure: transfer stays high until transfer_done.
// Ports: transfer/write_read/addr_in/wdata_in/strb_in (arbiter -> master),
//        transfer_done/error/rdata_out (master -> arbiter).
interface apb_master_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                    transfer;
    logic                    write_read;
    logic [ADDR_WIDTH-1:0]   addr_in;
    logic [DATA_WIDTH-1:0]   wdata_in;
    logic [DATA_WIDTH/8-1:0] strb_in;
    logic                    transfer_done;
    logic                    error;
    logic [DATA_WIDTH-1:0]   rdata_out;

    modport master (
        output transfer, write_read, addr_in, wdata_in, strb_in,
        input  transfer_done, error, rdata_out
    );

    modport slave (
        input  transfer, write_read, addr_in, wdata_in, strb_in,
        output transfer_done, error, rdata_out
    );
endinterface

// File: rtl/apb_master_arbiter_rr_pick.sv
// Round-robin pick: first set request at or above prio_ptr, wrapping.
// Latency: combinational.
// Backpressure: none.
// Ports: req, prio_ptr in; win_oh (one-hot), win_idx (binary), win_vld out.
module rr_pick #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] prio_ptr,
    output logic [N-1:0]     win_oh,
    output logic [IDX_W-1:0] win_idx,
    output logic             win_vld
);
    always_comb begin
        win_oh  = '0;
        win_idx = '0;
        win_vld = 1'b0;
        // Walk from the farthest slot back toward prio_ptr so the last hit,
        // i.e. the one nearest prio_ptr, is the one that sticks.
        for (int k = N - 1; k >= 0; k--) begin
            if (req[(int'(prio_ptr) + k) % N]) begin
                win_idx = IDX_W'((int'(prio_ptr) + k) % N);
                win_vld = 1'b1;
            end
        end
        if (win_vld) begin
            win_oh[win_idx] = 1'b1;
        end
    end
endmodule

// File: rtl/apb_master_arbiter.sv
// Round-robin share of one APB master command port among NUM_REQ requesters, with watchdog.
// Latency: gnt one edge after req; done one edge after transfer_done (or TIMEOUT_CYCLES after gnt).
// Backpressure: one command in flight; other requests wait in IDLE until the owner completes.
// Ports: pclk/preset; req/req_write/req_addr/req_wdata/req_strb in, gnt/done/resp_* out per requester;
//        apb (master modport) toward the APB master; busy/owner status.
module apb_master_arbiter
    import apb_arb_pkg::*;
#(
    parameter int  NUM_REQ        = 4,
    parameter int  ADDR_WIDTH     = APB_ADDR_W,
    parameter int  DATA_WIDTH     = APB_DATA_W,
    parameter int  TIMEOUT_CYCLES = 256,
    localparam int IDX_W          = $clog2(NUM_REQ),
    localparam int STRB_W         = DATA_WIDTH / 8
) (
    input  logic                          pclk,
    input  logic                          preset,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ-1:0]            req_write,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    input  logic [NUM_REQ*STRB_W-1:0]     req_strb,
    output logic [NUM_REQ-1:0]            gnt,
    output logic [NUM_REQ-1:0]            done,
    output logic [DATA_WIDTH-1:0]         resp_rdata,
    output logic                          resp_err,
    output logic                          resp_timeout,
    output logic                          busy,
    output logic [IDX_W-1:0]              owner,
    apb_master_arbiter_if.master          apb
);
    localparam int           CNT_W   = cnt_width(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

    arb_state_e              state_q, state_d;
    logic [IDX_W-1:0]        prio_q, prio_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d, cnt_inc;
    apb_cmd_t                cmd_q, cmd_d;
    logic                    xfer_q, xfer_d;
    logic [NUM_REQ-1:0]      gnt_q, gnt_d;
    logic [NUM_REQ-1:0]      done_q, done_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic                    err_q, err_d;
    logic                    tmo_q, tmo_d;
    logic [IDX_W-1:0]        owner_q, owner_d;
    logic                    tmo_hit;

    logic [NUM_REQ-1:0]      win_oh;
    logic [IDX_W-1:0]        win_idx;
    logic                    win_vld;

    rr_pick #(.N(NUM_REQ), .IDX_W(IDX_W)) u_pick (
        .req      (req),
        .prio_ptr (prio_q),
        .win_oh   (win_oh),
        .win_idx  (win_idx),
        .win_vld  (win_vld)
    );

    always_comb begin
        state_d = state_q;
        prio_d  = prio_q;
        cnt_d   = cnt_q;
        cmd_d   = cmd_q;
        xfer_d  = xfer_q;
        gnt_d   = '0;
        done_d  = '0;
        rdata_d = rdata_q;
        err_d   = err_q;
        tmo_d   = tmo_q;
        owner_d = owner_q;

        // Saturating count; timeout fires on the edge that brings it to TIMEOUT_CYCLES,
        // which is exactly TIMEOUT_CYCLES edges after the grant edge.
        cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
        tmo_hit = (TIMEOUT_CYCLES != 0) && (cnt_inc == CNT_MAX);

        case (state_q)
            IDLE: begin
                if (win_vld) begin
                    cmd_d.write = req_write[win_idx];
                    cmd_d.addr  = APB_ADDR_W'(req_addr[int'(win_idx)*ADDR_WIDTH +: ADDR_WIDTH]);
                    cmd_d.wdata = APB_DATA_W'(req_wdata[int'(win_idx)*DATA_WIDTH +: DATA_WIDTH]);
                    cmd_d.strb  = APB_STRB_W'(req_strb[int'(win_idx)*STRB_W +: STRB_W]);
                    xfer_d      = 1'b1;
                    gnt_d       = win_oh;
                    owner_d     = win_idx;
                    cnt_d       = '0;
                    state_d     = BUSY;
                end
            end
            BUSY: begin
                cnt_d = cnt_inc;
                if (apb.transfer_done || tmo_hit) begin
                    xfer_d          = 1'b0;
                    done_d[owner_q] = 1'b1;
                    // A real completion beats a coincident timeout.
                    rdata_d = apb.transfer_done ? apb.rdata_out : '0;
                    err_d   = apb.transfer_done ? apb.error : 1'b1;
                    tmo_d   = !apb.transfer_done;
                    prio_d  = (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + IDX_W'(1);
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state_q <= IDLE;
            prio_q  <= '0;
            cnt_q   <= '0;
            cmd_q   <= '0;
            xfer_q  <= 1'b0;
            gnt_q   <= '0;
            done_q  <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            tmo_q   <= 1'b0;
            owner_q <= '0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            cnt_q   <= cnt_d;
            cmd_q   <= cmd_d;
            xfer_q  <= xfer_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            tmo_q   <= tmo_d;
            owner_q <= owner_d;
        end
    end

    assign apb.transfer   = xfer_q;
    assign apb.write_read = cmd_q.write;
    assign apb.addr_in    = cmd_q.addr[ADDR_WIDTH-1:0];
    assign apb.wdata_in   = cmd_q.wdata[DATA_WIDTH-1:0];
    assign apb.strb_in    = cmd_q.strb[STRB_W-1:0];
    assign gnt            = gnt_q;
    assign done           = done_q;
    assign resp_rdata     = rdata_q;
    assign resp_err       = err_q;
    assign resp_timeout   = tmo_q;
    assign busy           = (state_q == BUSY);
    assign owner          = owner_q;
endmodule

// File: tb/tb_apb_master_arbiter.sv
// Directed bench for apb_master_arbiter: read, fairness, slave error, watchdog, mid-transfer reset.
// Latency: n/a.
// Backpressure: the bench plays the APB master by driving transfer_done.
module tb_apb_master_arbiter;
    localparam int NR = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int T  = 8;

    logic             pclk   = 1'b0;
    logic             preset = 1'b1;
    logic [NR-1:0]    req       = '0;
    logic [NR-1:0]    req_write = '0;
    logic [NR*AW-1:0] req_addr  = '0;
    logic [NR*DW-1:0] req_wdata = '0;
    logic [NR*SW-1:0] req_strb  = '0;
    logic [NR-1:0]    gnt, done;
    logic [DW-1:0]    resp_rdata;
    logic             resp_err, resp_timeout, busy;
    logic [1:0]       owner;

    int n_chk  = 0;
    int n_pass = 0;

    apb_master_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) apb_bus ();

    apb_master_arbiter #(
        .NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(T)
    ) dut (
        .pclk         (pclk),
        .preset       (preset),
        .req          (req),
        .req_write    (req_write),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_strb     (req_strb),
        .gnt          (gnt),
        .done         (done),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .resp_timeout (resp_timeout),
        .busy         (busy),
        .owner        (owner),
        .apb          (apb_bus.master)
    );

    always #5 pclk = ~pclk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    initial begin
        logic [NR-1:0] exp_oh;

        apb_bus.transfer_done = 1'b0;
        apb_bus.error         = 1'b0;
        apb_bus.rdata_out     = '0;

        // Reset state
        tick();
        tick();
        chk("rst_gnt",      64'(gnt), 64'h0);
        chk("rst_done",     64'(done), 64'h0);
        chk("rst_transfer", 64'(apb_bus.transfer), 64'h0);
        chk("rst_busy",     64'(busy), 64'h0);
        chk("rst_owner",    64'(owner), 64'h0);
        chk("rst_rdata",    64'(resp_rdata), 64'h0);
        preset = 1'b0;
        tick();

        // Single read from requester 1, completion 3 cycles after grant
        req                 = 4'b0010;
        req_write           = '0;
        req_addr[1*AW +: AW] = 32'h0000_0100;
        tick();
        chk("rd_gnt",      64'(gnt), 64'h2);
        chk("rd_transfer", 64'(apb_bus.transfer), 64'h1);
        chk("rd_busy",     64'(busy), 64'h1);
        chk("rd_owner",    64'(owner), 64'h1);
        chk("rd_addr",     64'(apb_bus.addr_in), 64'h100);
        chk("rd_wr",       64'(apb_bus.write_read), 64'h0);
        tick();
        chk("rd_gnt_pulse", 64'(gnt), 64'h0);
        chk("rd_xfer_c2",   64'(apb_bus.transfer), 64'h1);
        tick();
        chk("rd_xfer_c3",   64'(apb_bus.transfer), 64'h1);
        apb_bus.transfer_done = 1'b1;
        apb_bus.rdata_out     = 32'hDEAD_BEEF;
        req                   = '0;
        tick();
        apb_bus.transfer_done = 1'b0;
        chk("rd_done",     64'(done), 64'h2);
        chk("rd_rdata",    64'(resp_rdata), 64'hDEAD_BEEF);
        chk("rd_err",      64'(resp_err), 64'h0);
        chk("rd_xfer_off", 64'(apb_bus.transfer), 64'h0);
        chk("rd_busy_off", 64'(busy), 64'h0);

        // Round-robin fairness from a fresh prio_ptr of 0
        preset = 1'b1;
        tick();
        preset = 1'b0;
        tick();
        req                   = 4'b1111;
        apb_bus.transfer_done = 1'b1;
        apb_bus.rdata_out     = 32'h0;
        for (int k = 0; k < 5; k++) begin
            exp_oh = 4'b0001 << (k % NR);
            tick();
            chk("rr_gnt",   64'(gnt), 64'(exp_oh));
            chk("rr_xfer",  64'(apb_bus.transfer), 64'h1);
            tick();
            chk("rr_done",  64'(done), 64'(exp_oh));
            chk("rr_idle",  64'(apb_bus.transfer), 64'h0);
        end
        req                   = '0;
        apb_bus.transfer_done = 1'b0;
        tick();

        // Slave error on a write from requester 2 (prio_ptr is now 1)
        req                   = 4'b0100;
        req_write             = 4'b0100;
        req_addr[2*AW +: AW]  = 32'h0000_0020;
        req_wdata[2*DW +: DW] = 32'h0000_55AA;
        req_strb[2*SW +: SW]  = 4'b0011;
        tick();
        chk("err_gnt",   64'(gnt), 64'h4);
        chk("err_wr",    64'(apb_bus.write_read), 64'h1);
        chk("err_addr",  64'(apb_bus.addr_in), 64'h20);
        chk("err_wdata", 64'(apb_bus.wdata_in), 64'h55AA);
        chk("err_strb0", 64'(apb_bus.strb_in), 64'h3);
        req_strb[2*SW +: SW] = 4'b1111;
        tick();
        chk("err_strb1", 64'(apb_bus.strb_in), 64'h3);
        apb_bus.transfer_done = 1'b1;
        apb_bus.error         = 1'b1;
        apb_bus.rdata_out     = 32'h1234_5678;
        req                   = '0;
        tick();
        apb_bus.transfer_done = 1'b0;
        apb_bus.error         = 1'b0;
        chk("err_done",  64'(done), 64'h4);
        chk("err_err",   64'(resp_err), 64'h1);
        chk("err_tmo",   64'(resp_timeout), 64'h0);
        chk("err_strb2", 64'(apb_bus.strb_in), 64'h3);

        // Watchdog: requester 3, master never answers
        req = 4'b1000;
        tick();
        chk("tmo_gnt", 64'(gnt), 64'h8);
        req = '0;
        for (int i = 1; i < T; i++) begin
            tick();
            chk("tmo_wait", 64'(done), 64'h0);
        end
        tick();
        chk("tmo_done",  64'(done), 64'h8);
        chk("tmo_err",   64'(resp_err), 64'h1);
        chk("tmo_flag",  64'(resp_timeout), 64'h1);
        chk("tmo_rdata", 64'(resp_rdata), 64'h0);
        chk("tmo_xfer",  64'(apb_bus.transfer), 64'h0);

        // transfer_done on the timeout edge wins
        req = 4'b1000;
        tick();
        chk("tmo2_gnt", 64'(gnt), 64'h8);
        req = '0;
        for (int i = 1; i < T; i++) tick();
        apb_bus.transfer_done = 1'b1;
        apb_bus.rdata_out     = 32'hA5A5_A5A5;
        tick();
        apb_bus.transfer_done = 1'b0;
        chk("tmo2_done",  64'(done), 64'h8);
        chk("tmo2_flag",  64'(resp_timeout), 64'h0);
        chk("tmo2_err",   64'(resp_err), 64'h0);
        chk("tmo2_rdata", 64'(resp_rdata), 64'hA5A5_A5A5);

        // Reset while requester 2 owns the bus
        req       = 4'b0100;
        req_write = '0;
        tick();
        chk("mr_gnt",   64'(gnt), 64'h4);
        chk("mr_owner", 64'(owner), 64'h2);
        tick();
        preset = 1'b1;
        #1;
        chk("mr_xfer",  64'(apb_bus.transfer), 64'h0);
        chk("mr_busy",  64'(busy), 64'h0);
        chk("mr_owner0", 64'(owner), 64'h0);
        chk("mr_addr",  64'(apb_bus.addr_in), 64'h0);
        chk("mr_strb",  64'(apb_bus.strb_in), 64'h0);
        tick();
        chk("mr_nodone", 64'(done), 64'h0);
        preset = 1'b0;
        req    = 4'b0101;
        tick();
        chk("mr_regnt",  64'(gnt), 64'h1);
        chk("mr_reown",  64'(owner), 64'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
